// File: rtl/ps2_direction.sv
// PS/2 keyboard front end: receives scan codes, decodes arrow/WASD make codes and
// presents one one-hot movement command per video frame, latched on the rising edge of vs.
module ps2_direction #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       vs,
    output logic [3:0] Direction,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [3:0] PaDn    = 4'b0001;
    localparam logic [3:0] PaRight = 4'b0010;
    localparam logic [3:0] PaUp    = 4'b0100;
    localparam logic [3:0] PaLeft  = 4'b1000;
    localparam logic [3:0] Stop    = 4'b0000;

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    logic          r_clk_meta, r_clk_sync, r_data_meta, r_data_sync;
    logic          r_clk_filt, r_clk_filt_q;
    logic [FW-1:0] r_filt_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_bit;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_scan_code;
    logic          r_code_valid, r_frame_err;
    logic          r_vs_q;
    logic [3:0]    r_pending, r_direction;
    state_e        r_state, w_state_d;
    logic          w_fall, w_vs_rise, w_pend_wr;
    logic [3:0]    w_pend_val;

    assign w_fall    = r_clk_filt_q & ~r_clk_filt;
    assign w_vs_rise = vs & ~r_vs_q;

    // Synchronizers and glitch filter: a new ps2_clk level must persist FILTER cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_meta   <= 1'b1;
            r_clk_sync   <= 1'b1;
            r_data_meta  <= 1'b1;
            r_data_sync  <= 1'b1;
            r_clk_filt   <= 1'b1;
            r_clk_filt_q <= 1'b1;
            r_filt_cnt   <= '0;
        end else begin
            r_clk_meta   <= ps2_clk;
            r_clk_sync   <= r_clk_meta;
            r_data_meta  <= ps2_data;
            r_data_sync  <= r_data_meta;
            r_clk_filt_q <= r_clk_filt;
            if (r_clk_sync == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER - 1)) begin
                r_clk_filt <= r_clk_sync;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // Frame receiver: bit 0 start, 1..8 data LSB first, 9 parity, 10 stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_to_cnt     <= '0;
            r_scan_code  <= '0;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    if (!r_data_sync) r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt <= 4'd8) begin
                    r_shift   <= {r_data_sync, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
                    r_par_bit <= r_data_sync;
                    r_bit_cnt <= 4'd10;
                end else begin
                    r_bit_cnt <= 4'd0;
                    if (r_data_sync && (^r_shift ^ r_par_bit)) begin
                        r_scan_code  <= r_shift;
                        r_code_valid <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == TW'(TIMEOUT)) begin
                    r_bit_cnt   <= 4'd0;
                    r_to_cnt    <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_pend_wr  = 1'b0;
        w_pend_val = Stop;
        if (r_code_valid) begin
            unique case (r_state)
                StIdle: begin
                    case (r_scan_code)
                        8'hE0:   w_state_d = StExt;
                        8'hF0:   w_state_d = StBrk;
                        8'h1D:   begin w_pend_wr = 1'b1; w_pend_val = PaUp;    end
                        8'h1B:   begin w_pend_wr = 1'b1; w_pend_val = PaDn;    end
                        8'h1C:   begin w_pend_wr = 1'b1; w_pend_val = PaLeft;  end
                        8'h23:   begin w_pend_wr = 1'b1; w_pend_val = PaRight; end
                        default: w_state_d = StIdle;
                    endcase
                end
                StExt: begin
                    w_state_d = StIdle;
                    case (r_scan_code)
                        8'hF0:   w_state_d = StExtBrk;
                        8'h75:   begin w_pend_wr = 1'b1; w_pend_val = PaUp;    end
                        8'h72:   begin w_pend_wr = 1'b1; w_pend_val = PaDn;    end
                        8'h6B:   begin w_pend_wr = 1'b1; w_pend_val = PaLeft;  end
                        8'h74:   begin w_pend_wr = 1'b1; w_pend_val = PaRight; end
                        default: w_state_d = StIdle;
                    endcase
                end
                StBrk:    w_state_d = StIdle;
                StExtBrk: w_state_d = StIdle;
                default:  w_state_d = StIdle;
            endcase
        end
    end

    // A write colliding with vs_rise wins over the clear, so it survives into the next frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_vs_q      <= 1'b0;
            r_pending   <= Stop;
            r_direction <= Stop;
        end else begin
            r_state <= w_state_d;
            r_vs_q  <= vs;
            if (w_vs_rise) r_direction <= r_pending;
            if (w_pend_wr) begin
                r_pending <= w_pend_val;
            end else if (w_vs_rise) begin
                r_pending <= Stop;
            end
        end
    end

    assign Direction  = r_direction;
    assign scan_code  = r_scan_code;
    assign code_valid = r_code_valid;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_direction.sv
// Scoreboard bench for ps2_direction: stimulus queues expected events and frame commands,
// forked monitors pop and compare when the DUT reports them.
module tb_ps2_direction;

    localparam int unsigned FILT = 4;
    localparam int unsigned TO   = 200;

    logic       clk = 1'b0;
    logic       reset, ps2_clk, ps2_data, vs;
    logic [3:0] Direction;
    logic [7:0] scan_code;
    logic       code_valid, frame_err;

    typedef struct packed {
        logic       is_err;
        logic [7:0] code;
    } ev_t;

    ev_t        ev_q[$];
    logic [3:0] dir_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] last_dir;

    always #5 clk = ~clk;

    ps2_direction #(.FILTER(FILT), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .vs        (vs),
        .Direction (Direction),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
        return {1'b1, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(10);
        ps2_clk = 1'b0;
        tick(10);
        ps2_clk = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
        tick(20);
    endtask

    task automatic send_byte(input logic [7:0] d);
        ev_q.push_back('{is_err: 1'b0, code: d});
        send_bits(mk_frame(d, 1'b0), 11);
    endtask

    task automatic pulse_vs(input logic [3:0] exp);
        check("dir_hold", 32'(Direction), 32'(last_dir));
        dir_q.push_back(exp);
        last_dir = exp;
        vs = 1'b1;
        tick(5);
        vs = 1'b0;
        tick(5);
    endtask

    task automatic mon_events();
        ev_t e;
        forever begin
            @(negedge clk);
            if (code_valid || frame_err) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: valid=%0b err=%0b code=%0h expected none",
                             code_valid, frame_err, scan_code);
                end else begin
                    e = ev_q.pop_front();
                    check("event_err", 32'(frame_err), 32'(e.is_err));
                    check("event_valid", 32'(code_valid), 32'(!e.is_err));
                    if (!e.is_err) check("scan_code", 32'(scan_code), 32'(e.code));
                end
            end
        end
    endtask

    // Direction must be updated by the second falling clk edge after vs rises.
    task automatic mon_dir();
        forever begin
            @(posedge vs);
            @(negedge clk);
            @(negedge clk);
            if (dir_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got %0b expected none", Direction);
            end else begin
                check("direction", 32'(Direction), 32'(dir_q.pop_front()));
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        vs       = 1'b0;
        last_dir = 4'b0000;
        fork
            mon_events();
            mon_dir();
        join_none
        tick(3);
        check("rst_direction", 32'(Direction), 32'h0);
        check("rst_scan_code", 32'(scan_code), 32'h0);
        check("rst_code_valid", 32'(code_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        tick(2);

        // extended arrow make, one frame only
        send_byte(8'hE0);
        send_byte(8'h75);
        pulse_vs(4'b0100);
        pulse_vs(4'b0000);

        // break sequences produce no command
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1C);
        pulse_vs(4'b1000);
        pulse_vs(4'b0000);

        // last key wins
        send_byte(8'h1D);
        send_byte(8'h23);
        pulse_vs(4'b0010);

        // bad parity
        ev_q.push_back('{is_err: 1'b1, code: 8'h00});
        send_bits(mk_frame(8'h1B, 1'b1), 11);
        pulse_vs(4'b0000);

        // stall mid-frame, then a clean frame
        ev_q.push_back('{is_err: 1'b1, code: 8'h00});
        send_bits(mk_frame(8'h1B, 1'b0), 4);
        tick(TO + 40);
        send_byte(8'h1B);
        pulse_vs(4'b0001);

        // collision: 1C written in the vs_rise cycle, 1D pending already
        send_byte(8'h1D);
        check("dir_hold", 32'(Direction), 32'(last_dir));
        fork
            send_byte(8'h1C);
            begin : raise_vs
                int n;
                n = 0;
                while (!code_valid && n < 2000) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                if (!code_valid) begin
                    checks++;
                    failures++;
                    $display("FAIL collision_wait: got no code_valid expected one within 2000");
                end
                dir_q.push_back(4'b0100);
                last_dir = 4'b0100;
                vs = 1'b1;
                tick(5);
                vs = 1'b0;
                tick(5);
            end
        join
        pulse_vs(4'b1000);

        // reset mid-frame
        send_byte(8'h1D);
        pulse_vs(4'b0100);
        send_byte(8'h23);
        send_bits(mk_frame(8'h75, 1'b0), 4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_direction", 32'(Direction), 32'h0);
        check("midrst_scan_code", 32'(scan_code), 32'h0);
        check("midrst_code_valid", 32'(code_valid), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        last_dir = 4'b0000;
        tick(2);
        pulse_vs(4'b0000);
        send_byte(8'h1B);
        pulse_vs(4'b0001);

        tick(20);
        check("events_drained", 32'(ev_q.size()), 32'h0);
        check("frames_drained", 32'(dir_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
